// File: rtl/arp_rx_parser.sv
// ARP request receive parser.
// Watches a byte stream of Ethernet frames (preamble/SFD stripped, FCS kept),
// checks that the frame is an ARP request for LOCAL_IP addressed to broadcast
// or LOCAL_MAC, captures the sender MAC/IP, and reports the FCS verdict.
//
// Ports:
//   aclk, areset         clock, synchronous active-high reset
//   rx_data/valid/last   received bytes; rx_last marks the final FCS byte
//   rq_mac_s_addr        SHA of the last accepted ARP request
//   rq_ip_s_addr         SPA of the last accepted ARP request
//   arp_data_done        1-cycle pulse, header bytes 0..41 all passed
//   crc_valid/crc_error  1-cycle pulse, FCS/length verdict of an accepted frame
module arp_rx_parser #(
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_010A,
    parameter logic [47:0] LOCAL_MAC = 48'h84A0_DAB8_3142
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic [47:0] rq_mac_s_addr,
    output logic [31:0] rq_ip_s_addr,
    output logic        arp_data_done,
    output logic        crc_valid,
    output logic        crc_error
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    logic [1:0]  state_q;
    logic [6:0]  idx_q;
    logic [31:0] crc_q;
    logic        bc_q, uc_q;       // dst MAC still matches broadcast / LOCAL_MAC
    logic [47:0] sha_q;
    logic [31:0] spa_q;
    logic        runt_pend_q;      // header ended exactly on byte 41

    logic [6:0]  cur_idx, idx_next;
    logic        in_hdr, bc_n, uc_n, byte_ok, len_ok;
    logic [7:0]  mac_byte;
    logic [31:0] crc_next;

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    always_comb begin
        // In IDLE the incoming byte is byte 0 of a new frame and is checked now.
        cur_idx  = (state_q == ST_IDLE) ? 7'd0 : idx_q;
        in_hdr   = (state_q == ST_IDLE) || (state_q == ST_HDR);
        idx_next = (cur_idx == 7'd127) ? cur_idx : cur_idx + 7'd1;
        len_ok   = (cur_idx >= 7'd63);          // this byte is at least the 64th
        crc_next = crc_step(crc_q, rx_data);

        mac_byte = 8'd0;
        case (cur_idx)
            7'd0: mac_byte = LOCAL_MAC[47:40];
            7'd1: mac_byte = LOCAL_MAC[39:32];
            7'd2: mac_byte = LOCAL_MAC[31:24];
            7'd3: mac_byte = LOCAL_MAC[23:16];
            7'd4: mac_byte = LOCAL_MAC[15:8];
            7'd5: mac_byte = LOCAL_MAC[7:0];
            default: mac_byte = 8'd0;
        endcase

        bc_n = ((cur_idx == 7'd0) || bc_q) && (rx_data == 8'hFF);
        uc_n = ((cur_idx == 7'd0) || uc_q) && (rx_data == mac_byte);

        byte_ok = 1'b1;
        case (cur_idx)
            7'd0, 7'd1, 7'd2,
            7'd3, 7'd4, 7'd5: byte_ok = bc_n || uc_n;
            7'd12: byte_ok = (rx_data == 8'h08);
            7'd13: byte_ok = (rx_data == 8'h06);
            7'd14: byte_ok = (rx_data == 8'h00);
            7'd15: byte_ok = (rx_data == 8'h01);
            7'd16: byte_ok = (rx_data == 8'h08);
            7'd17: byte_ok = (rx_data == 8'h00);
            7'd18: byte_ok = (rx_data == 8'h06);
            7'd19: byte_ok = (rx_data == 8'h04);
            7'd20: byte_ok = (rx_data == 8'h00);
            7'd21: byte_ok = (rx_data == 8'h01);
            7'd38: byte_ok = (rx_data == LOCAL_IP[31:24]);
            7'd39: byte_ok = (rx_data == LOCAL_IP[23:16]);
            7'd40: byte_ok = (rx_data == LOCAL_IP[15:8]);
            7'd41: byte_ok = (rx_data == LOCAL_IP[7:0]);
            default: byte_ok = 1'b1;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= ST_IDLE;
            idx_q         <= 7'd0;
            crc_q         <= CRC_INIT;
            bc_q          <= 1'b0;
            uc_q          <= 1'b0;
            sha_q         <= 48'd0;
            spa_q         <= 32'd0;
            runt_pend_q   <= 1'b0;
            rq_mac_s_addr <= 48'd0;
            rq_ip_s_addr  <= 32'd0;
            arp_data_done <= 1'b0;
            crc_valid     <= 1'b0;
            crc_error     <= 1'b0;
        end else begin
            arp_data_done <= 1'b0;
            crc_valid     <= 1'b0;
            crc_error     <= runt_pend_q;
            runt_pend_q   <= 1'b0;

            if (rx_valid) begin
                // rx_last re-arms counter and CRC so a byte next cycle is byte 0.
                crc_q <= rx_last ? CRC_INIT : crc_next;
                idx_q <= rx_last ? 7'd0 : idx_next;
                bc_q  <= bc_n;
                uc_q  <= uc_n;

                if (in_hdr && cur_idx >= 7'd22 && cur_idx <= 7'd27)
                    sha_q <= {sha_q[39:0], rx_data};
                if (in_hdr && cur_idx >= 7'd28 && cur_idx <= 7'd31)
                    spa_q <= {spa_q[23:0], rx_data};

                case (state_q)
                    ST_IDLE, ST_HDR: begin
                        if (!byte_ok) begin
                            state_q <= rx_last ? ST_IDLE : ST_DROP;
                        end else if (cur_idx == 7'd41) begin
                            // Sender fields are complete since byte 31.
                            arp_data_done <= 1'b1;
                            rq_mac_s_addr <= sha_q;
                            rq_ip_s_addr  <= spa_q;
                            state_q       <= rx_last ? ST_IDLE : ST_TAIL;
                            runt_pend_q   <= rx_last;
                        end else begin
                            state_q <= rx_last ? ST_IDLE : ST_HDR;
                        end
                    end
                    ST_TAIL: begin
                        if (rx_last) begin
                            state_q <= ST_IDLE;
                            if (crc_next == CRC_RESIDUE && len_ok)
                                crc_valid <= 1'b1;
                            else
                                crc_error <= 1'b1;
                        end
                    end
                    default: begin
                        if (rx_last)
                            state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
